// File: rtl/s2a_pkg.sv
// Shared types and helpers for the multi-channel stream-to-AXI controller.
package s2a_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_PRE,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/s2a_rr_arb.sv
// Round-robin pick of the next channel with a pending half,
// searching upward from the one after last_grant.
module s2a_rr_arb #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] last_grant,
  output logic [CHW-1:0] grant,
  output logic           valid
);

  int idx;
  logic [CHW-1:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NCH) idx = idx - NCH;
      cand = CHW'(idx);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/s2a_mc_controller.sv
// Multi-channel ping-pong stream buffers drained as fixed
// INCR bursts on a single AXI write port.
module s2a_mc_controller
  import s2a_pkg::*;
#(
  parameter  int NCH        = 4,
  parameter  int BURST_LEN  = 16,
  parameter  int DATA_BYTES = 4,
  parameter  int SIZE_W     = 18,
  localparam int BW  = clog2(BURST_LEN),
  localparam int CHW = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic                   Sclk,
  input  logic                   rst,
  input  logic                   sync,
  input  logic [NCH-1:0]         Ien,
  output logic [NCH*(BW+1)-1:0]  Iaddr,
  input  logic [NCH*32-1:0]      ibase,
  input  logic [NCH*SIZE_W-1:0]  isize,
  output logic [NCH*SIZE_W-1:0]  iacnt,
  output logic [NCH*32-1:0]      ibcnt,
  output logic [NCH-1:0]         ovf,
  output logic                   werr,
  output logic [CHW-1:0]         s2a_ch,
  output logic [BW:0]            s2a_addr,
  output logic                   s2a_en,
  output logic [31:0]            AXI_awaddr,
  output logic [7:0]             AXI_awlen,
  output logic                   AXI_awvalid,
  input  logic                   AXI_awready,
  output logic                   AXI_wvalid,
  output logic                   AXI_wlast,
  input  logic                   AXI_wready,
  input  logic                   AXI_bvalid,
  input  logic [1:0]             AXI_bresp,
  output logic                   AXI_bready
);

  localparam int BBW = clog2(BURST_LEN * DATA_BYTES);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  state_t state;
  logic [CHW-1:0] ch, last_grant, gnt;
  logic gnt_vld, stale, rel_any;
  logic [NCH-1:0] req;
  logic [NCH-1:0][31:0] base_a;
  logic [NCH-1:0][SIZE_W-1:0] size_a;
  logic [NCH-1:0][SIZE_W-1:0] rd_blk;
  logic [NCH-1:0] rd_half;

  assign base_a    = ibase;
  assign size_a    = isize;
  assign AXI_awlen = 8'(BURST_LEN - 1);
  assign s2a_ch    = ch;

  assign s2a_en = (state == S_PRE) |
    ((state == S_DATA) & AXI_wvalid &
     AXI_wready & ~AXI_wlast);

  // A burst granted before a sync must not touch the cleared pointers.
  assign rel_any = (state == S_DATA) & AXI_wvalid &
    AXI_wready & AXI_wlast & ~stale;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [BW-1:0] beat;
    logic half, done, rel, of;
    logic [SIZE_W-1:0] acnt;
    logic [31:0] bcnt;
    logic [1:0] pend;
    logic [SIZE_W-1:0] sz;

    assign sz   = size_a[g];
    assign done = Ien[g] & (beat == LAST);
    assign rel  = rel_any & (ch == CHW'(g));

    always_ff @(posedge Sclk or posedge rst) begin
      if (rst) begin
        beat <= '0;
        half <= 1'b0;
        acnt <= '0;
        bcnt <= '0;
        pend <= '0;
        of   <= 1'b0;
      end else if (sync) begin
        beat <= '0;
        half <= 1'b0;
        acnt <= '0;
        bcnt <= '0;
        pend <= '0;
        of   <= 1'b0;
      end else begin
        if (Ien[g]) beat <= beat + 1'b1;
        if (done) begin
          half <= ~half;
          if (acnt == sz - 1'b1) begin
            acnt <= '0;
            bcnt <= bcnt + 1'b1;
          end else begin
            acnt <= acnt + 1'b1;
          end
        end
        case ({done, rel})
          2'b10: begin
            if (pend == 2'd2) of <= 1'b1;
            else pend <= pend + 1'b1;
          end
          2'b01:   pend <= pend - 1'b1;
          default: ;
        endcase
      end
    end

    assign Iaddr[g*(BW+1) +: BW+1]   = {half, beat};
    assign iacnt[g*SIZE_W +: SIZE_W] = acnt;
    assign ibcnt[g*32 +: 32]         = bcnt;
    assign ovf[g]                    = of;
    assign req[g]                    = (pend != 2'd0);
  end

  s2a_rr_arb #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (gnt),
    .valid      (gnt_vld)
  );

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ch          <= '0;
      last_grant  <= CHW'(NCH - 1);
      AXI_awaddr  <= '0;
      AXI_awvalid <= 1'b0;
      AXI_wvalid  <= 1'b0;
      AXI_wlast   <= 1'b0;
      AXI_bready  <= 1'b0;
      s2a_addr    <= '0;
      werr        <= 1'b0;
      stale       <= 1'b0;
      rd_blk      <= '0;
      rd_half     <= '0;
    end else begin
      if (sync) stale <= 1'b1;
      unique case (state)
        S_IDLE: begin
          stale <= sync;
          if (gnt_vld) begin
            ch          <= gnt;
            last_grant  <= gnt;
            AXI_awaddr  <= base_a[gnt] +
              (32'(rd_blk[gnt]) << BBW);
            s2a_addr    <= {rd_half[gnt], BW'(0)};
            AXI_awvalid <= 1'b1;
            state       <= S_AW;
          end
        end
        S_AW: begin
          if (AXI_awready) begin
            AXI_awvalid <= 1'b0;
            state       <= S_PRE;
          end
        end
        S_PRE: begin
          s2a_addr[BW-1:0] <= s2a_addr[BW-1:0] + 1'b1;
          AXI_wvalid <= 1'b1;
          AXI_wlast  <= 1'b0;
          state      <= S_DATA;
        end
        S_DATA: begin
          if (AXI_wready) begin
            if (AXI_wlast) begin
              AXI_wvalid <= 1'b0;
              AXI_wlast  <= 1'b0;
              AXI_bready <= 1'b1;
              state      <= S_RESP;
              if (!stale) begin
                rd_half[ch] <= ~rd_half[ch];
                if (rd_blk[ch] == size_a[ch] - 1'b1)
                  rd_blk[ch] <= '0;
                else
                  rd_blk[ch] <= rd_blk[ch] + 1'b1;
              end
            end else begin
              s2a_addr[BW-1:0] <= s2a_addr[BW-1:0] + 1'b1;
              AXI_wlast <= (s2a_addr[BW-1:0] == LAST);
            end
          end
        end
        S_RESP: begin
          if (AXI_bvalid) begin
            AXI_bready <= 1'b0;
            if (AXI_bresp != AXI_OKAY) werr <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (sync) begin
        rd_blk  <= '0;
        rd_half <= '0;
      end
    end
  end

endmodule

// File: doc/s2a_mc_controller.md
# s2a_mc_controller

Multi-channel stream-to-AXI burst write controller. It is the parametrised successor of the single-channel stream-to-AXI controller. NCH stream channels each fill a private two-half ping-pong bank in an external buffer RAM. Completed halves are issued round-robin as fixed-length INCR bursts on one AXI write port, into per-channel circular regions in DDR. Overflow is reported per channel, and write-response errors are reported globally.

## Interface
- NCH, 4: number of stream channels (1..16)
- BURST_LEN, 16: beats per burst and per buffer half (power of two, 2..256)
- DATA_BYTES, 4: bytes per beat (power of two)
- SIZE_W, 18: width of region size and block counters
- Derived: BW=log2(BURST_LEN), CHW=max(1,log2(NCH)), BURST_BYTES=BURST_LEN*DATA_BYTES
- Sclk  in  1  single clock for the stream and AXI sides
- rst  in  1  asynchronous, active-high reset
- sync  in  1  synchronous restart of all channels
- Ien  in  NCH  per-channel write strobe (one word per cycle)
- Iaddr  out  NCH*(BW+1)  per-channel bank write address {half, beat}
- ibase  in  NCH*32  per-channel region base, aligned to BURST_BYTES
- isize  in  NCH*SIZE_W  region size in bursts, must be at least 1
- iacnt  out  NCH*SIZE_W  per-channel write block index
- ibcnt  out  NCH*32  per-channel region wrap count
- ovf  out  NCH  sticky overflow flag per channel
- werr  out  1  sticky flag, set when BRESP is not OKAY
- s2a_ch  out  CHW  buffer read bank select
- s2a_addr  out  BW+1  buffer read address {half, beat}; read data appears 1 cycle later on WDATA
- s2a_en  out  1  buffer read enable (combinational)
- AXI_awaddr  out  32  AXI_awlen  out  8 (constant BURST_LEN-1)  AXI_awvalid  out  1  AXI_awready  in  1
- AXI_wvalid  out  1  AXI_wlast  out  1  AXI_wready  in  1
- AXI_bvalid  in  1  AXI_bresp  in  2  AXI_bready  out  1

## Operation
- Write side, per channel c: each Ien[c] advances a beat counter. Iaddr[c] = {wr_half, beat}.
- When beat == BURST_LEN-1 under Ien (a block completes):
  - beat wraps to 0 and wr_half toggles.
  - iacnt increments. At isize-1 it wraps to 0 and ibcnt increments (ibcnt wraps at 2^32).
  - pend[c] (range 0..2) increments.
- Overflow: if pend==2 when a block completes with no simultaneous release, set ovf[c], hold pend at 2, and overwrite the half.
- Release: the last W beat of a channel's burst is accepted → pend decrements.
  - A simultaneous completion and release leaves pend unchanged.
- State machine: IDLE, AW, PRE, DATA, RESP.
- IDLE: round-robin grant to the first channel with pend>0, searching from last_grant+1 upward and wrapping. Register:
  - ch
  - AXI_awaddr = ibase[ch] + rd_blk[ch]*BURST_BYTES
  - s2a_addr = {rd_half[ch], 0}
  - then go to AW.
- AW: AXI_awvalid=1. On awready, drop awvalid and go to PRE.
- PRE: s2a_en=1 for one cycle (prefetch of beat 0), then go to DATA.
- DATA:
  - AXI_wvalid=1.
  - s2a_en = wvalid & wready & ~wlast.
  - s2a_addr beat field increments on each s2a_en.
  - AXI_wlast=1 while the presented beat is BURST_LEN-1.
  - On the last beat accepted: release pend, toggle rd_half[ch], advance rd_blk[ch] (wrap at isize-1), go to RESP.
- RESP: AXI_bready=1. On bvalid, set werr if bresp≠0, then go to IDLE.
- sync: clears beat, half, iacnt, ibcnt, pend, rd_blk, rd_half and ovf for every channel.
  - An in-flight AXI transaction completes protocol-correctly but does not release pend or advance pointers.
- No AW is issued while RESP is pending; at most one burst is outstanding.

## Timing
- Reset values: all counters 0, ovf=0, werr=0, state IDLE.
  - awvalid, wvalid, wlast, bready, s2a_en: 0.
  - awaddr=0, s2a_ch=0, s2a_addr=0.
  - last_grant = NCH-1, so channel 0 wins first.
- Latency with ready signals held high:
  - Block completion → awvalid: 2 cycles (pend register update, then the IDLE grant).
  - awvalid → first wvalid: 2 cycles (the AW beat, then PRE).
- A burst occupies BURST_LEN+3 cycles plus the B latency. Sustained service across all channels must exceed the aggregate Ien rate, or ovf is raised.
- wvalid is never deasserted mid-burst. AXI outputs are held stable while valid is high and ready is low.
- isize changes take effect at the next wrap comparison; software changes them only under sync.
- rst mid-burst aborts immediately; AXI compliance across rst is not required.

## Structure
- Package s2a_pkg: the state enum, the AXI_OKAY constant, and the width helper function for BW/CHW.
- Sub-module s2a_rr_arb:
  - Inputs: NCH request vector and last_grant.
  - Outputs: grant index and valid.
  - Combinational, instantiated once.

## Test plan
- NCH=4, BURST_LEN=16, ready signals high. Ch0 writes 16 words, ibase0=0x1000_0000 → one burst at 0x1000_0000 with awlen=15. wlast is on beat 15, s2a_addr runs 0x00..0x0F, and iacnt0=1.
- Ch0 and ch2 complete blocks in the same cycle → ch0 is issued first, then ch2, with no gap beyond the IDLE cycle. Repeat → ch2 is not starved.
- isize1=3, ch1 writes 4 blocks → addresses base, +64, +128, then base again; ibcnt1=1 after the 3rd block.
- awready held low for 50 cycles while ch3 completes 3 blocks → ovf[3]=1 and pend stays 2. The other channels' ovf bits stay 0.
- wready toggling 1/0 throughout a burst → exactly 16 s2a_en pulses and data order preserved. A bresp=2 response sets werr.
- sync asserted during DATA → the burst completes with 16 beats and wlast, all counters read 0, and no pend underflow occurs.
